// File: rtl/kw_tile_gather.sv
// kw_tile_gather: double-buffered collector of WIDTH_1-bit rows into WIDTH_0-row packed tiles
module kw_tile_gather #(
  parameter int WIDTH_0 = 4,
  parameter int WIDTH_1 = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH_1-1:0]                 in_row,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH_0-1:0][WIDTH_1-1:0]    out_tile,
  output logic [$clog2(WIDTH_0+1)-1:0]       out_rows
);
  localparam int CW = (WIDTH_0 > 1) ? $clog2(WIDTH_0) : 1;
  localparam int RW = $clog2(WIDTH_0 + 1);
  logic [WIDTH_0-1:0][WIDTH_1-1:0] bank_q [2];
  logic [WIDTH_0-1:0][WIDTH_1-1:0] bank_d [2];
  logic [RW-1:0] rows_q [2];
  logic [RW-1:0] rows_d [2];
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic in_acc, out_acc, tile_close;
  // handshakes and the presented tile come from registered state only
  always_comb begin
    in_ready   = !full_q[wr_bank_q];
    out_valid  = full_q[rd_bank_q];
    out_tile   = out_valid ? bank_q[rd_bank_q] : '0;
    out_rows   = out_valid ? rows_q[rd_bank_q] : '0;
    in_acc     = in_valid && in_ready;
    out_acc    = out_valid && out_ready;
    tile_close = in_last || (row_cnt_q == CW'(WIDTH_0 - 1));
  end
  // read side frees rd_bank while write side fills wr_bank; both firing always hit different banks
  always_comb begin
    bank_d    = bank_q;
    rows_d    = rows_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_cnt_d = row_cnt_q;
    if (out_acc) begin
      full_d[rd_bank_q] = 1'b0;
      bank_d[rd_bank_q] = '0;
      rd_bank_d         = !rd_bank_q;
    end
    if (in_acc) begin
      bank_d[wr_bank_q][row_cnt_q] = in_row;
      full_d[wr_bank_q] = full_d[wr_bank_q] | tile_close;
      rows_d[wr_bank_q] = tile_close ? RW'(row_cnt_q) + RW'(1) : rows_d[wr_bank_q];
      wr_bank_d         = wr_bank_q ^ tile_close;
      row_cnt_d         = tile_close ? '0 : row_cnt_q + CW'(1);
    end
  end
  // state registers; reset drops partial and held tiles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q    <= '{default: '0};
      rows_q    <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      bank_q    <= bank_d;
      rows_q    <= rows_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_cnt_q <= row_cnt_d;
    end
  end
endmodule

// File: tb/tb_kw_tile_gather.sv
// tb_kw_tile_gather: directed and random checks of kw_tile_gather against a tile queue model
module tb_kw_tile_gather;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_row = '0;
  logic in_ready, out_valid;
  logic [3:0][7:0] out_tile;
  logic [2:0] out_rows;
  int total = 0, bad = 0, pops = 0, cnt = 0;
  logic [31:0] cur = '0;
  logic [31:0] q_tile [$];
  int q_rows [$];

  kw_tile_gather #(.WIDTH_0(4), .WIDTH_1(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_tile(out_tile), .out_rows(out_rows)
  );

  always #5 clk = !clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] row, input logic last, input logic ordy);
    logic held;
    logic [31:0] ht;
    logic [2:0] hr;
    in_valid = iv; in_row = row; in_last = last; out_ready = ordy;
    #1;
    chk("valid_vs_model", out_valid, 64'(q_tile.size() > 0));
    chk("ready_vs_model", in_ready, 64'(q_tile.size() < 2));
    held = out_valid && !out_ready;
    ht = out_tile;
    hr = out_rows;
    if (out_valid && out_ready && q_tile.size() > 0) begin
      chk("tile", out_tile, q_tile.pop_front());
      chk("rows", out_rows, q_rows.pop_front());
      pops++;
    end
    if (iv && in_ready) begin
      cur[cnt*8 +: 8] = row;
      if (cnt == 3 || last) begin
        q_tile.push_back(cur);
        q_rows.push_back(cnt + 1);
        cur = '0;
        cnt = 0;
      end else cnt++;
    end
    @(posedge clk); #1;
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_tile", out_tile, ht);
      chk("hold_rows", out_rows, hr);
    end
  endtask

  initial begin
    int p0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_tile", out_tile, 0);
    chk("rst_rows", out_rows, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    // full tile, latency one cycle after closing row
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_tile", out_tile, 32'h44332211);
    chk("t1_rows", out_rows, 4);
    step(0, 0, 0, 1);
    // early close, then bank reuse must not show stale rows
    step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 1, 0);
    chk("t2_tile", out_tile, 32'h00A3A2A1);
    chk("t2_rows", out_rows, 3);
    step(1, 8'hB1, 0, 1); step(1, 8'hB2, 0, 0); step(1, 8'hB3, 0, 0); step(1, 8'hB4, 0, 0);
    chk("t2b_tile", out_tile, 32'hB4B3B2B1);
    step(1, 8'hC1, 1, 1);
    chk("t2c_tile", out_tile, 32'h000000C1);
    chk("t2c_rows", out_rows, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    chk("t2_empty", out_valid, 0);
    // backpressure fills both banks
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    chk("t3_ready_low", in_ready, 0);
    chk("t3_tile", out_tile, 32'h04030201);
    step(1, 8'h99, 0, 0);
    step(0, 0, 0, 1);
    chk("t3_next", out_tile, 32'h08070605);
    chk("t3_ready_back", in_ready, 1);
    step(0, 0, 0, 1);
    // continuous stream at full rate
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      chk("t4_no_stall", in_ready, 1);
      step(1, 8'($urandom_range(0, 255)), 0, 1);
    end
    step(0, 0, 0, 1);
    chk("t4_tiles", pops - p0, 16);
    // reset mid-tile with one tile held
    for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i), 0, 0);
    chk("t5_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_tile", out_tile, 0);
    chk("t5_ready", in_ready, 1);
    q_tile.delete(); q_rows.delete(); cur = '0; cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 8'hD1, 0, 0); step(1, 8'hD2, 0, 0); step(1, 8'hD3, 0, 0); step(1, 8'hD4, 0, 0);
    chk("t5_tile_new", out_tile, 32'hD4D3D2D1);
    chk("t5_rows_new", out_rows, 4);
    step(0, 0, 0, 1);
    // random traffic against the queue model
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    chk("drained", q_tile.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kw_tile_gather.md
Name: kw_tile_gather

Overview:
- Upstream feeder for the packed-2D bit transpose stage.
- Collects a stream of WIDTH_1-bit rows into WIDTH_0-row packed tiles. Each tile is presented as a single packed word [WIDTH_0-1:0][WIDTH_1-1:0] that feeds the transpose directly.
- Double-buffered: one bank fills while the other is held for the consumer, so the block sustains one row per cycle.
- Valid/ready handshake on both sides. A tile can be closed early with in_last.

Parameters:
- WIDTH_0, 4: rows per tile (outer packed dimension); must be >= 1.
- WIDTH_1, 8: bits per row (inner packed dimension); must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_row/in_last are valid.
- in_ready  output  1  block can accept a row this cycle.
- in_row  input  WIDTH_1  row data; written to tile row index = current row count.
- in_last  input  1  closes the current tile after this row.
- out_valid  output  1  a complete tile is presented.
- out_ready  input  1  consumer accepts the tile.
- out_tile  output  [WIDTH_0-1:0][WIDTH_1-1:0]  packed tile; out_tile[r] is the r-th accepted row.
- out_rows  output  $clog2(WIDTH_0+1)  number of valid rows in out_tile (1..WIDTH_0).

Behaviour:
- State:
  - two tile banks, bank[0..1];
  - per-bank full flag and row count;
  - wr_bank and rd_bank pointers;
  - row_cnt, range 0..WIDTH_0-1.
- Reset (async assert, sync release): all banks zero, full = 0, wr_bank = rd_bank = 0, row_cnt = 0. Outputs: out_valid = 0, out_tile = 0, out_rows = 0, in_ready = 1.
- in_ready = !full[wr_bank]. It is a function of registered state only, with no combinational path from out_ready.
- Input accept (in_valid && in_ready):
  - bank[wr_bank][row_cnt] <= in_row.
  - If row_cnt == WIDTH_0-1 or in_last:
    - full[wr_bank] <= 1;
    - rows[wr_bank] <= row_cnt+1;
    - wr_bank toggles;
    - row_cnt <= 0.
  - Otherwise row_cnt increments.
- in_last on the row at index WIDTH_0-1 is identical to a normal close. in_last is ignored when in_valid = 0.
- Output presentation:
  - out_valid = full[rd_bank];
  - out_tile = bank[rd_bank] when out_valid, else 0;
  - out_rows = rows[rd_bank] when out_valid, else 0.
- Output transfer (out_valid && out_ready):
  - full[rd_bank] <= 0;
  - bank[rd_bank] <= 0 (the clear ensures unfilled rows of an early-closed tile read as zero);
  - rd_bank toggles.
- Latency: a tile appears on out_tile/out_valid the cycle after its closing row is accepted.
- Stability: while out_valid && !out_ready, out_tile and out_rows hold constant.
- Simultaneous input accept and output transfer in the same cycle are legal. They always touch different banks, so both take effect.
- Both banks full: in_ready = 0 and row_cnt holds. in_ready returns to 1 the cycle after an output transfer.
- Throughput: with out_ready held at 1, an unbroken in_valid stream is accepted every cycle without stalls.
- Reset mid-tile discards the partial tile and any held tiles.
- WIDTH_0 = 1: every accepted row closes a tile, and out_rows is always 1.
- Assertions:
  - no in_row change while in_valid && !in_ready is not required (the input is sampled only on accept);
  - out_valid must never drop without out_ready.

Test Plan (WIDTH_0=4, WIDTH_1=8):
- Reset, then 4 rows 0x11,0x22,0x33,0x44 with out_ready=1 → 1 cycle after the 4th accept: out_valid=1, out_tile=0x44332211, out_rows=4.
- 3 rows 0xA1,0xA2,0xA3 with in_last on the third → out_tile=0x00A3A2A1, out_rows=3. The following full tile has no stale data in row 3.
- out_ready=0, stream 8 rows 0x01..0x08 → in_ready drops after the 8th accept and out_tile holds 0x04030201. Raise out_ready for 1 cycle → next tile is 0x08070605, and in_ready=1 on the following cycle.
- 64-cycle continuous in_valid with out_ready=1 and random data → in_ready is never 0; 16 tiles arrive in order and match the golden model.
- Assert rst mid-tile after 2 rows while one full tile is held → out_valid=0, out_tile=0 and in_ready=1 immediately. The next 4 rows form a fresh tile with out_rows=4.
- Random in_valid/out_ready/in_last for 10k cycles → scoreboard matches every tile and out_rows. out_tile is stable under backpressure.
